// File: rtl/bnn_pkg.sv
// Shared constants and types for the binarized network layer-1 datapath.
package bnn_pkg;

  localparam int IN_WIDTH   = 784;  // bits per image and per w1 row
  localparam int OUT_WIDTH  = 512;  // neurons in layer 1 (rows of w1)
  localparam int ADDR_WIDTH = 9;    // w1 ROM address width
  localparam int CNT_WIDTH  = 10;   // popcount width, holds up to 1023 >= IN_WIDTH

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/element_compute_a1.sv
// Combinational binarized neuron: compares the number of active pixels that
// meet a +1 weight against the number that meet a -1 weight. Ties resolve to 1.
module element_compute_a1
  import bnn_pkg::*;
#(
  parameter int WIDTH = IN_WIDTH
) (
  input  logic [WIDTH-1:0] i_row,     // weight row, bit 0 encodes -1
  input  logic [WIDTH-1:0] i_col,     // binarized image, 1 = pixel on
  output logic             o_result
);

  logic [CNT_WIDTH-1:0] w_pos;
  logic [CNT_WIDTH-1:0] w_neg;

  // Count pixels on against +1 weights (pos) and against -1 weights (neg).
  always_comb begin
    // NOTE: combinational logic uses blocking assignments, and every variable gets a default first so no latch is inferred.
    w_pos = '0;
    w_neg = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i_col[i]) begin
        if (i_row[i]) w_pos = w_pos + CNT_WIDTH'(1);
        else          w_neg = w_neg + CNT_WIDTH'(1);
      end
    end
  end

  assign o_result = (w_pos >= w_neg);

endmodule

// File: rtl/layer1_sequencer.sv
// Layer-1 sequencer: walks the 512 rows of w1 in an external synchronous ROM,
// evaluates one neuron per cycle and hands the packed a1 vector to layer 2
// over a valid/ready handshake.
// Optional build macro LAYER1_PIPE_EN inserts a register stage between the
// ROM output and the neuron unit (one extra cycle of latency).
module layer1_sequencer
  import bnn_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IN_WIDTH-1:0]   x_in,
  output logic                  busy,
  output logic                  rom_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [IN_WIDTH-1:0]   rom_data,
  output logic [OUT_WIDTH-1:0]  a1_out,
  output logic                  a1_valid,
  input  logic                  a1_ready
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(OUT_WIDTH - 1);

  state_t                r_state;
  logic [IN_WIDTH-1:0]   r_x;
  logic                  r_rd_vld;   // rom_data carries a requested row this cycle
  logic [ADDR_WIDTH-1:0] r_rd_idx;   // row index of the data on rom_data

  logic [IN_WIDTH-1:0]   w_row;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_vld;
  logic                  w_result;

  // Track which ROM row is returning: the write index trails the address by the ROM latency.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      r_rd_vld <= 1'b0;
      r_rd_idx <= '0;
    end else begin
      r_rd_vld <= rom_en;
      r_rd_idx <= rom_addr;
    end
  end

`ifdef LAYER1_PIPE_EN
  logic [IN_WIDTH-1:0]   r_row_q;
  logic [ADDR_WIDTH-1:0] r_idx_q;
  logic                  r_vld_q;

  // Register the ROM row and its index ahead of the wide popcount path; cleared so no stale row survives a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_q <= '0;
      r_idx_q <= '0;
      r_vld_q <= 1'b0;
    end else begin
      r_row_q <= rom_data;
      r_idx_q <= r_rd_idx;
      r_vld_q <= r_rd_vld;
    end
  end

  assign w_row = r_row_q;
  assign w_idx = r_idx_q;
  assign w_vld = r_vld_q;
`else
  assign w_row = rom_data;
  assign w_idx = r_rd_idx;
  assign w_vld = r_rd_vld;
`endif

  element_compute_a1 #(
    .WIDTH (IN_WIDTH)
  ) u_neuron (
    .i_row    (w_row),
    .i_col    (r_x),
    .o_result (w_result)
  );

  // Control FSM: capture the image, sweep the ROM addresses, collect neuron results, hold a1 until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_x      <= '0;
      busy     <= 1'b0;
      rom_en   <= 1'b0;
      rom_addr <= '0;
      a1_out   <= '0;
      a1_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_x      <= x_in;
            a1_out   <= '0;
            rom_en   <= 1'b1;
            rom_addr <= '0;
            busy     <= 1'b1;
            r_state  <= RUN;
          end
        end

        RUN: begin
          // Address sweep stops at the last row; it never wraps inside a run.
          if (rom_en) begin
            if (rom_addr == LAST_ADDR) rom_en   <= 1'b0;
            else                       rom_addr <= rom_addr + 1'b1;
          end
          if (w_vld) begin
            a1_out[w_idx] <= w_result;
            if (w_idx == LAST_ADDR) begin
              a1_valid <= 1'b1;
              r_state  <= DONE;
            end
          end
        end

        DONE: begin
          // a1_out and a1_valid hold until downstream accepts; start is ignored here.
          if (a1_ready) begin
            a1_valid <= 1'b0;
            busy     <= 1'b0;
            rom_addr <= '0;
            r_state  <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
